fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have one clock and synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have imem_req  out  1  instruction-memory read request, one word per asserted cycle.
REQ-004 SHALL have imem_addr  out  32  byte address of the request; bits [1:0] always 0.
REQ-005 SHALL have imem_rdata  in  32  read data, valid when imem_rvalid=1.
REQ-006 SHALL have imem_rvalid  in  1  asserted exactly one cycle after each accepted request; responses return in order.
REQ-007 SHALL have stall  in  1  decode stage not accepting this cycle.
REQ-008 SHALL have branch_taken  in  1  redirect request.
REQ-009 SHALL have pc_branch  in  32  redirect target.
REQ-010 SHALL have instruction  out  instruction_type  instruction word presented to decode.
REQ-011 SHALL have pc  out  32  address of the presented instruction.
REQ-012 SHALL have valid  out  1  instruction/pc hold a live instruction.

Function
REQ-013 SHALL implement FSM states BOOT, RUN and FLUSH: BOOT->RUN unconditionally; RUN->FLUSH on branch_taken; FLUSH->RUN unconditionally.
REQ-014 SHALL issue no request in BOOT or FLUSH, and SHALL ignore imem_rvalid in those states.
REQ-015 SHALL drive valid=1 exactly when the 2-entry output FIFO is non-empty; instruction/pc come from the FIFO head.
REQ-016 SHALL pop the FIFO head on a cycle with valid=1 and stall=0.
REQ-017 In RUN with branch_taken=0, SHALL assert imem_req when outstanding + count - pop < 2, where outstanding is 0 or 1, count is the FIFO occupancy and pop is 1 when REQ-016 pops.
REQ-018 On each issued request, SHALL set imem_addr=fetch_pc, record fetch_pc as the in-flight tag, and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-019 SHALL push {imem_rdata, tag} into the FIFO on imem_rvalid in RUN; push and pop in the same cycle SHALL keep the occupancy unchanged.
REQ-020 On branch_taken in RUN, SHALL load fetch_pc with {pc_branch[31:2],2'b00}, flush the FIFO (valid=0 next cycle), and drop any in-flight response.
REQ-021 SHALL give branch_taken priority over stall, push and pop in the same cycle.
REQ-022 SHALL make the first request after a redirect address the target, in the cycle after FLUSH.
REQ-023 SHALL never drop or duplicate an instruction while stall is held, and SHALL stop requests once occupancy reaches 2.
REQ-024 SHALL give steady-state throughput of one instruction per cycle with stall=0.
REQ-025 SHALL have first-fetch latency, counting cycle 0 as the first cycle with rst=0: cycle 1 req RESET_PC, cycle 2 rvalid, cycle 3 valid=1 with pc=RESET_PC.

Reset
REQ-026 On rst=1 at a clock edge, SHALL set state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0.
REQ-027 During and after reset, SHALL hold outputs at valid=0, imem_req=0, imem_addr=0, instruction=0 and pc=0 until the reset-driven values change.
REQ-028 When reset is asserted mid-operation, SHALL discard the in-flight response arriving in the first post-reset cycle, via BOOT.

Structure
REQ-029 SHALL place fetch_state_type (BOOT/RUN/FLUSH) and the constant INSTR_BYTES=4 in package common, alongside instruction_type.
REQ-030 SHALL implement the output buffer as sub-module fetch_fifo: 2 entries of {32-bit word, 32-bit pc}, with push, pop, flush, count, head.

Verification
REQ-031 SHALL cover reset release with stall=0: req addresses 0,4,8,... from cycle 1; valid from cycle 3; pc sequence 0,4,8 on consecutive cycles.
REQ-032 SHALL cover stall held 5 cycles from pc=8: valid stays 1, pc stays 8, imem_req drops within 2 cycles; after release pc 8,C,10 with no gap or duplicate.
REQ-033 SHALL cover branch_taken with pc_branch=32'h100 while one request is in flight: the stale response is dropped, valid=0 next cycle, next req addr 32'h100, and the next valid pc is 32'h100.
REQ-034 SHALL cover branch_taken with stall=1 and a full FIFO in the same cycle: the FIFO flushes, and only target instructions appear afterwards.
REQ-035 SHALL cover fetch_pc=32'hFFFF_FFFC: the next request wraps to 32'h0; pc_branch=32'h103 fetches 32'h100.
REQ-036 SHALL cover rst=1 mid-stream with rvalid=1 in the next cycle: that response is dropped, and the sequence restarts at RESET_PC per REQ-025.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage
package common;

  typedef logic [31:0] instruction_type;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_type;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - two-entry {word, pc} buffer between imem and decode
module fetch_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_word,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic [31:0] head_word,
  output logic [31:0] head_pc
);

  logic [31:0] word_q [2];
  logic [31:0] pc_q   [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  // flush wins over push/pop so a redirect never leaves stale entries behind
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q[0] <= '0;
      word_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
    end else if (push && !flush) begin
      word_q[wr_ptr_q] <= push_word;
      pc_q[wr_ptr_q]   <= push_pc;
    end
  end

  assign count     = count_q;
  assign head_word = word_q[rd_ptr_q];
  assign head_pc   = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one-deep imem pipelining and redirect flush
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [31:0]     pc_branch,
  output instruction_type instruction,
  output logic [31:0]     pc,
  output logic            valid
);

  fetch_state_type state_q, state_d;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     tag_q;
  logic            outstanding_q;
  logic [1:0]      count;
  logic [31:0]     head_word;
  logic [31:0]     head_pc;
  logic            push;
  logic            pop;
  logic            flush;
  logic [2:0]      demand;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (branch_taken) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // demand counts entries that will occupy the buffer after this cycle's pop
  always_comb begin
    valid       = (count != 2'd0);
    pop         = valid && !stall;
    demand      = {1'b0, count} + {2'b00, outstanding_q} - {2'b00, pop};
    imem_req    = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    if (state_q == RUN) begin
      if (branch_taken) begin
        flush = 1'b1;
      end else begin
        imem_req = (demand < 3'd2);
        push     = imem_rvalid && outstanding_q;
      end
    end
    imem_addr   = imem_req ? fetch_pc_q : 32'h0;
    instruction = valid ? head_word : '0;
    pc          = valid ? head_pc : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      tag_q         <= 32'h0;
      outstanding_q <= 1'b0;
    end else begin
      outstanding_q <= imem_req;
      if (flush) begin
        fetch_pc_q <= pc_branch & 32'hFFFF_FFFC;
      end else if (imem_req) begin
        tag_q      <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + INSTR_BYTES;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (imem_rdata),
    .push_pc   (tag_q),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_word (head_word),
    .head_pc   (head_pc)
  );

endmodule
